// File: rtl/coproc_instr_decoder.sv
// Decodes the HPS instruction word, issues one command to the coprocessor core
// with a valid/ready handshake, waits for completion under a timeout and publishes status.
module coproc_instr_decoder #(
  parameter int unsigned TIMEOUT = 32'd1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [28:0] instr_in,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_opcode,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  input  logic        core_done,
  input  logic        core_error,
  input  logic [15:0] core_result,
  output logic [31:0] status_out,
  output logic        done_pulse
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_EXEC  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_r;
  logic             start_q_r;
  logic [CNT_W-1:0] cnt_r;
  logic [15:0]      result_r;
  logic             busy_r;
  logic             done_r;
  logic             error_r;
  logic             ignored_r;

  logic             start_edge_s;
  logic             timeout_s;
  logic [2:0]       op_s;
  logic             unused_s;

  assign start_edge_s = instr_in[28] & ~start_q_r;
  assign timeout_s    = (cnt_r == TMO_LAST);
  assign op_s         = instr_in[27:25];
  // Reserved bit 16 carries no meaning for this block.
  assign unused_s     = instr_in[16];

  assign status_out = {result_r, cmd_addr, cmd_opcode, 1'b0, ignored_r, error_r, done_r, busy_r};

  // Control FSM, command registers and sticky status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      start_q_r  <= 1'b1;
      cnt_r      <= {CNT_W{1'b0}};
      cmd_valid  <= 1'b0;
      cmd_opcode <= 3'b000;
      cmd_addr   <= 8'h00;
      cmd_data   <= 16'h0000;
      result_r   <= 16'h0000;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      ignored_r  <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      start_q_r  <= instr_in[28];
      done_pulse <= 1'b0;
      if (start_edge_s && (state_r != ST_IDLE)) begin
        ignored_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (start_edge_s) begin
            cmd_opcode <= op_s;
            cmd_addr   <= instr_in[24:17];
            cmd_data   <= instr_in[15:0];
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            ignored_r  <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            case (op_s)
              OP_LOAD, OP_STORE, OP_EXEC: begin
                state_r   <= ST_ISSUE;
                cmd_valid <= 1'b1;
                busy_r    <= 1'b1;
              end
              OP_NOP: begin
                state_r    <= ST_DONE;
                done_r     <= 1'b1;
                done_pulse <= 1'b1;
              end
              default: begin
                state_r    <= ST_DONE;
                done_r     <= 1'b1;
                error_r    <= 1'b1;
                done_pulse <= 1'b1;
              end
            endcase
          end
        end
        ST_ISSUE: begin
          // Timeout takes priority over a handshake on the same edge.
          if (timeout_s) begin
            state_r    <= ST_DONE;
            cmd_valid  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            error_r    <= 1'b1;
            done_pulse <= 1'b1;
          end else if (cmd_ready) begin
            state_r   <= ST_WAIT;
            cmd_valid <= 1'b0;
            cnt_r     <= cnt_r + CNT_ONE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_WAIT: begin
          // Completion beats a coincident timeout.
          if (core_done) begin
            state_r    <= ST_DONE;
            result_r   <= core_result;
            error_r    <= core_error;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            done_pulse <= 1'b1;
          end else if (timeout_s) begin
            state_r    <= ST_DONE;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            error_r    <= 1'b1;
            done_pulse <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_DONE: begin
          if (!instr_in[28]) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          cmd_valid <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coproc_instr_decoder.sv
// Self-checking bench for coproc_instr_decoder: directed vector table, corner-case
// sequences and random transactions against a transaction-level timing model.
module tb_coproc_instr_decoder;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [28:0] instr_in;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_opcode;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        core_done;
  logic        core_error;
  logic [15:0] core_result;
  logic [31:0] status_out;
  logic        done_pulse;

  int n_checks = 0;
  int n_errors = 0;

  coproc_instr_decoder #(.TIMEOUT(T)) dut (
    .clk(clk), .reset_n(reset_n), .instr_in(instr_in),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .core_done(core_done),
    .core_error(core_error), .core_result(core_result),
    .status_out(status_out), .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  addr;
    logic [15:0] data;
    int          rd;
    int          j;
    logic        err;
    logic [15:0] res;
    int          e_v;
    int          e_p;
    logic        e_err;
    logic [15:0] e_res;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected outcome of one transaction, derived from launch/handshake/timeout rules.
  task automatic model(input logic [2:0] op, input int rd, input int j, input logic err,
                       input logic [15:0] res, input logic [15:0] prev,
                       output int e_v, output int e_p, output logic e_err, output logic [15:0] e_res);
    if (!(op inside {3'd1, 3'd2, 3'd3})) begin
      e_v = 0; e_p = 1; e_err = (op != 3'd0); e_res = prev;
    end else if (rd <= T - 2) begin
      e_v = rd + 1;
      if (rd + 1 + j <= T - 1) begin
        e_p = rd + 3 + j; e_err = err; e_res = res;
      end else begin
        e_p = T + 1; e_err = 1'b1; e_res = prev;
      end
    end else begin
      e_v = T; e_p = T + 1; e_err = 1'b1; e_res = prev;
    end
  endtask

  // Launches one instruction and plays a reactive core: ready after rd valid cycles,
  // done j cycles into WAIT. Returns what was observed.
  task automatic run_txn(input logic [2:0] op, input logic [7:0] addr, input logic [15:0] data,
                         input int rd, input int j, input logic err, input logic [15:0] res,
                         output int vcnt, output int fv_c, output int p_c, output int p_n,
                         output int b_n, output int bad, output logic [31:0] st);
    int   xfer_c;
    logic rbit;
    vcnt = 0; fv_c = 0; p_c = 0; p_n = 0; b_n = 0; bad = 0; xfer_c = 0;
    rbit = 1'($urandom_range(0, 1));
    core_error = err; core_result = res; cmd_ready = 1'b0; core_done = 1'b0;
    instr_in = {1'b1, op, addr, rbit, data};
    for (int c = 1; c <= T + 12; c++) begin
      step();
      if (cmd_valid) begin
        if (fv_c == 0) fv_c = c;
        if (cmd_opcode !== op || cmd_addr !== addr || cmd_data !== data) bad++;
        cmd_ready = (vcnt >= rd);
        if (cmd_ready) xfer_c = c;
        vcnt++;
      end else begin
        cmd_ready = 1'b0;
      end
      core_done = (xfer_c > 0) && (c == xfer_c + 1 + j);
      if (done_pulse) begin
        p_n++;
        if (p_c == 0) p_c = c;
      end
      if (status_out[0]) b_n++;
    end
    st = status_out;
    cmd_ready = 1'b0; core_done = 1'b0; instr_in[28] = 1'b0;
    step();
  endtask

  task automatic txn_checked(input string tag, input logic [2:0] op, input logic [7:0] addr,
                             input logic [15:0] data, input int rd, input int j, input logic err,
                             input logic [15:0] res, input int e_v, input int e_p,
                             input logic e_err, input logic [15:0] e_res);
    int vcnt, fv_c, p_c, p_n, b_n, bad;
    logic [31:0] st;
    run_txn(op, addr, data, rd, j, err, res, vcnt, fv_c, p_c, p_n, b_n, bad, st);
    check({tag, "_valid_cycles"}, 32'(vcnt), 32'(e_v));
    check({tag, "_valid_start"}, 32'(fv_c), (e_v > 0) ? 32'd1 : 32'd0);
    check({tag, "_pulse_cycle"}, 32'(p_c), 32'(e_p));
    check({tag, "_pulse_count"}, 32'(p_n), 32'd1);
    check({tag, "_busy_cycles"}, 32'(b_n), (e_v > 0) ? 32'(e_p - 1) : 32'd0);
    check({tag, "_cmd_fields"}, 32'(bad), 32'd0);
    check({tag, "_status"}, st, {e_res, addr, op, 1'b0, 1'b0, e_err, 1'b1, 1'b0});
  endtask

  vec_t tbl[9];

  initial begin
    logic [15:0] prev_res;
    int e_v, e_p;
    logic e_err;
    logic [15:0] e_res;
    logic [2:0]  r_op;
    logic [7:0]  r_addr;
    logic [15:0] r_data, r_res;
    logic        r_err;
    int          r_rd, r_j, seen;

    tbl[0] = '{3'd1, 8'h12, 16'hBEEF, 0,  0, 1'b0, 16'h1111, 1, 3, 1'b0, 16'h1111};
    tbl[1] = '{3'd2, 8'h34, 16'h5678, 3,  2, 1'b0, 16'h1234, 4, 8, 1'b0, 16'h1234};
    tbl[2] = '{3'd3, 8'h56, 16'h0000, 0,  6, 1'b1, 16'hABCD, 1, 9, 1'b1, 16'hABCD};
    tbl[3] = '{3'd3, 8'h9A, 16'h00FF, 0,  7, 1'b0, 16'h9999, 1, 9, 1'b1, 16'hABCD};
    tbl[4] = '{3'd3, 8'hC3, 16'hFFFF, 15, 0, 1'b0, 16'h2222, 8, 9, 1'b1, 16'hABCD};
    tbl[5] = '{3'd5, 8'h11, 16'h1357, 0,  0, 1'b0, 16'h3333, 0, 1, 1'b1, 16'hABCD};
    tbl[6] = '{3'd0, 8'h22, 16'h2468, 0,  0, 1'b0, 16'h4444, 0, 1, 1'b0, 16'hABCD};
    tbl[7] = '{3'd3, 8'h7E, 16'h8001, 6,  0, 1'b0, 16'h0F0F, 7, 9, 1'b0, 16'h0F0F};
    tbl[8] = '{3'd2, 8'hE7, 16'h4004, 7,  0, 1'b1, 16'h5A5A, 8, 9, 1'b1, 16'h0F0F};

    // Reset released with start already high: nothing may launch.
    reset_n = 1'b0; cmd_ready = 1'b0; core_done = 1'b0; core_error = 1'b0;
    core_result = 16'h0000; instr_in = {1'b1, 3'd1, 8'h12, 1'b0, 16'hBEEF};
    #1;
    check("rst_status", status_out, 32'h0);
    check("rst_valid", 32'(cmd_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1; reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (cmd_valid || done_pulse || status_out != 32'h0) seen++;
    end
    check("rst_high_start_no_launch", 32'(seen), 32'd0);
    check("rst_high_start_status", status_out, 32'h0);
    instr_in[28] = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      txn_checked($sformatf("tbl%0d", i), tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].rd,
                  tbl[i].j, tbl[i].err, tbl[i].res, tbl[i].e_v, tbl[i].e_p, tbl[i].e_err,
                  tbl[i].e_res);
    end
    prev_res = 16'h0F0F;

    // Start re-pulsed during WAIT is dropped but flagged; completion still reported.
    core_result = 16'h4242; core_error = 1'b0; cmd_ready = 1'b1;
    instr_in = {1'b1, 3'd3, 8'hA5, 1'b0, 16'h0102};
    step();
    check("ign_valid", 32'(cmd_valid), 32'd1);
    step();
    cmd_ready = 1'b0;
    check("ign_in_wait", status_out[1:0], 2'b01);
    instr_in[28] = 1'b0;
    step();
    instr_in[28] = 1'b1;
    step();
    check("ign_flag", status_out, {16'h0F0F, 8'hA5, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    check("ign_done_status", status_out, {16'h4242, 8'hA5, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    check("ign_done_pulse", 32'(done_pulse), 32'd1);
    instr_in[28] = 1'b0;
    step();
    prev_res = 16'h4242;
    model(3'd1, 0, 0, 1'b0, 16'h7777, prev_res, e_v, e_p, e_err, e_res);
    txn_checked("ign_clear", 3'd1, 8'h3C, 16'hC0DE, 0, 0, 1'b0, 16'h7777, e_v, e_p, e_err, e_res);
    prev_res = e_res;

    // Reset in WAIT aborts at once; a late completion afterwards is ignored.
    cmd_ready = 1'b1;
    instr_in = {1'b1, 3'd2, 8'h77, 1'b0, 16'h3333};
    step();
    cmd_ready = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    check("rstw_valid", 32'(cmd_valid), 32'd0);
    check("rstw_status", status_out, 32'h0);
    check("rstw_cmd", {5'd0, cmd_opcode, cmd_addr, cmd_data}, 32'h0);
    check("rstw_pulse", 32'(done_pulse), 32'd0);
    instr_in[28] = 1'b0;
    @(posedge clk);
    #1; reset_n = 1'b1;
    core_done = 1'b1; core_result = 16'h5555;
    seen = 0;
    step();
    core_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (cmd_valid || done_pulse || status_out != 32'h0) seen++;
      step();
    end
    check("rstw_late_done_ignored", 32'(seen), 32'd0);
    prev_res = 16'h0000;
    model(3'd3, 1, 1, 1'b0, 16'h6161, prev_res, e_v, e_p, e_err, e_res);
    txn_checked("rstw_after", 3'd3, 8'h01, 16'h0202, 1, 1, 1'b0, 16'h6161, e_v, e_p, e_err, e_res);
    prev_res = e_res;

    for (int i = 0; i < 40; i++) begin
      r_op   = 3'($urandom_range(0, 7));
      r_addr = 8'($urandom);
      r_data = 16'($urandom);
      r_res  = 16'($urandom);
      r_err  = 1'($urandom_range(0, 1));
      r_rd   = $urandom_range(0, 9);
      r_j    = $urandom_range(0, 9);
      model(r_op, r_rd, r_j, r_err, r_res, prev_res, e_v, e_p, e_err, e_res);
      txn_checked($sformatf("rnd%0d", i), r_op, r_addr, r_data, r_rd, r_j, r_err, r_res,
                  e_v, e_p, e_err, e_res);
      prev_res = e_res;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
